// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared seven-segment types, glyph constants and hex decoder
// Segment codes are active-low, bit order g..a (bit 6 = g, bit 0 = a).
package hex_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    // Not driven by the scanner yet; kept here so future display modes share it.
    localparam seg_t SEG_DASH  = 7'h3F;

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// rtl/hex_seg_lut.sv - combinational nibble to active-low seven-segment converter
// Ports:
//   nibble_i  in   4  hex digit value
//   seg_o     out  7  active-low segments, g..a
module hex_seg_lut
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/hex_scan_display.sv
// rtl/hex_scan_display.sv - time-multiplexed hex driver for common-anode seven-segment digits
// Ports:
//   clk_i         in   1             system clock
//   rst_i         in   1             synchronous active-high reset
//   value_i       in   4*NUM_DIGITS  packed nibbles, nibble k -> digit k
//   load_i        in   1             capture value_i/blank_i/lzs_en_i into shadows
//   blank_i       in   NUM_DIGITS    per-digit force-blank mask
//   lzs_en_i      in   1             leading-zero suppression enable
//   digit_sel_no  out  NUM_DIGITS    active-low one-hot anode enables
//   segments_no   out  7             active-low segments, g..a
//   frame_done_o  out  1             one-clock pulse when the last slot ends
module hex_scan_display
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD_CYCLES = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    load_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    lzs_en_i,
    output logic [NUM_DIGITS-1:0]   digit_sel_no,
    output logic [6:0]              segments_no,
    output logic                    frame_done_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0]        prescaler_q, prescaler_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    lzs_q, lzs_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    seg_t                    segments_q, segments_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end;
    logic                    last_digit;
    logic                    in_guard;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_nibble;
    logic                    cur_blank;
    seg_t                    cur_glyph;

    hex_seg_lut u_lut (
        .nibble_i (cur_nibble),
        .seg_o    (cur_glyph)
    );

    always_comb begin
        slot_end     = (prescaler_q == CNT_W'(SCAN_DIV - 1));
        last_digit   = (index_q == IDX_W'(NUM_DIGITS - 1));
        in_guard     = ({1'b0, prescaler_q} < (CNT_W + 1)'(GUARD_CYCLES));

        prescaler_d  = slot_end ? '0 : prescaler_q + CNT_W'(1);
        index_d      = index_q;
        if (slot_end) begin
            index_d = last_digit ? '0 : index_q + IDX_W'(1);
        end
        frame_done_d = slot_end && last_digit;

        value_d = value_q;
        blank_d = blank_q;
        lzs_d   = lzs_q;
        if (load_i) begin
            value_d = value_i;
            blank_d = blank_i;
            lzs_d   = lzs_en_i;
        end

        // Walk down from the top digit: a digit is suppressed only while
        // every nibble from the top down to it is zero. Digit 0 never is.
        lz_mask  = '0;
        zero_run = lzs_q;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (value_q[k*4 +: 4] == 4'h0);
            lz_mask[k] = zero_run;
        end

        cur_nibble  = 4'h0;
        cur_blank   = 1'b0;
        digit_sel_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index_q == IDX_W'(k)) begin
                cur_nibble = value_q[k*4 +: 4];
                cur_blank  = blank_q[k] || lz_mask[k];
                if (!in_guard) begin
                    digit_sel_d[k] = 1'b0;
                end
            end
        end

        segments_d = cur_blank ? SEG_BLANK : cur_glyph;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prescaler_q  <= '0;
            index_q      <= '0;
            value_q      <= '0;
            blank_q      <= '0;
            lzs_q        <= 1'b0;
            digit_sel_q  <= '1;
            segments_q   <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            index_q      <= index_d;
            value_q      <= value_d;
            blank_q      <= blank_d;
            lzs_q        <= lzs_d;
            digit_sel_q  <= digit_sel_d;
            segments_q   <= segments_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_sel_no = digit_sel_q;
    assign segments_no  = segments_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// tb/tb_hex_scan_display.sv - self-checking bench for hex_scan_display
module tb_hex_scan_display;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int GC = 1;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [15:0]   value_i;
    logic          load_i;
    logic [3:0]    blank_i;
    logic          lzs_en_i;
    logic [3:0]    digit_sel_no;
    logic [6:0]    segments_no;
    logic          frame_done_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         digit;
        logic [6:0] seg;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [15:0] value;
        logic [3:0]  blank;
        logic        lzs;
        logic [6:0]  seg [4];
        string       name;
    } vec_t;
    vec_t vecs[$];

    hex_scan_display #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .value_i      (value_i),
        .load_i       (load_i),
        .blank_i      (blank_i),
        .lzs_en_i     (lzs_en_i),
        .digit_sel_no (digit_sel_no),
        .segments_no  (segments_no),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done_o && n < 64);
        if (!frame_done_o) begin
            total++;
            bad++;
            $display("FAIL %s: frame_done timeout got 0 expected 1", name);
        end
    endtask

    task automatic add_vec(input logic [15:0] v, input logic [3:0] b, input logic l,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input string name);
        vec_t t;
        t.value = v; t.blank = b; t.lzs = l; t.name = name;
        t.seg[0] = s0; t.seg[1] = s1; t.seg[2] = s2; t.seg[3] = s3;
        vecs.push_back(t);
    endtask

    task automatic load_vec(input logic [15:0] v, input logic [3:0] b, input logic l);
        @(negedge clk);
        value_i  = v;
        blank_i  = b;
        lzs_en_i = l;
        load_i   = 1'b1;
        @(negedge clk);
        load_i   = 1'b0;
    endtask

    // Aligns to a frame boundary, queues the four expected digits, then
    // walks one full frame checking anodes, segments and the frame strobe.
    task automatic run_frame(input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3, input string name);
        logic [6:0] exp_seg [4];
        sb_t        cur;
        logic [3:0] exp_an;
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
        cur.digit = 0; cur.seg = 7'h7F;
        wait_frame_done(name);
        for (int d = 0; d < N; d++) begin
            sb_t e;
            e.digit = d;
            e.seg   = exp_seg[d];
            sb_q.push_back(e);
        end
        for (int c = 0; c < N * SD; c++) begin
            int pos = c % SD;
            int d   = c / SD;
            @(negedge clk);
            exp_an = (pos < GC) ? 4'hF : ~(4'b0001 << d);
            check({name, " anode"}, {28'h0, digit_sel_no}, {28'h0, exp_an});
            check({name, " frame_done"}, {31'h0, frame_done_o}, {31'h0, (c == N * SD - 1)});
            if (pos == GC) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL %s: scoreboard empty got 0 expected 1", name);
                end else begin
                    cur = sb_q.pop_front();
                end
            end
            if (pos >= GC) begin
                check($sformatf("%s seg d%0d", name, cur.digit), {25'h0, segments_no}, {25'h0, cur.seg});
            end
        end
    endtask

    initial begin
        rst_i    = 1'b1;
        load_i   = 1'b0;
        value_i  = 16'h0;
        blank_i  = 4'h0;
        lzs_en_i = 1'b0;

        add_vec(16'h0000, 4'b0000, 1'b1, 7'h40, 7'h7F, 7'h7F, 7'h7F, "zero_lzs");
        add_vec(16'hBEEF, 4'b0000, 1'b0, 7'h0E, 7'h06, 7'h06, 7'h03, "beef");
        add_vec(16'h0050, 4'b0000, 1'b1, 7'h40, 7'h12, 7'h7F, 7'h7F, "lzs_0050");
        add_vec(16'h1234, 4'b0101, 1'b1, 7'h7F, 7'h30, 7'h7F, 7'h79, "blank_1234");
        add_vec(16'h0050, 4'b0010, 1'b1, 7'h40, 7'h7F, 7'h7F, 7'h7F, "blank_over_lzs");
        add_vec(16'h9876, 4'b0000, 1'b1, 7'h02, 7'h78, 7'h00, 7'h10, "glyphs_6789");
        add_vec(16'hA0C0, 4'b0000, 1'b1, 7'h40, 7'h46, 7'h40, 7'h08, "inner_zeros");
        add_vec(16'h0D21, 4'b0000, 1'b0, 7'h79, 7'h24, 7'h21, 7'h40, "glyphs_12d");

        repeat (3) @(negedge clk);
        check("reset anode", {28'h0, digit_sel_no}, 32'hF);
        check("reset seg", {25'h0, segments_no}, 32'h7F);
        check("reset frame_done", {31'h0, frame_done_o}, 32'h0);
        rst_i = 1'b0;

        run_frame(7'h40, 7'h40, 7'h40, 7'h40, "idle");

        foreach (vecs[i]) begin
            load_vec(vecs[i].value, vecs[i].blank, vecs[i].lzs);
            run_frame(vecs[i].seg[0], vecs[i].seg[1], vecs[i].seg[2], vecs[i].seg[3], vecs[i].name);
        end

        // Reset while index=2, prescaler=3, with a simultaneous load of FFFF.
        load_vec(16'hBEEF, 4'b0000, 1'b0);
        wait_frame_done("rst_mid");
        repeat (11) @(negedge clk);
        check("pre_rst anode", {28'h0, digit_sel_no}, 32'hB);
        rst_i    = 1'b1;
        load_i   = 1'b1;
        value_i  = 16'hFFFF;
        lzs_en_i = 1'b1;
        @(negedge clk);
        check("rst_mid anode", {28'h0, digit_sel_no}, 32'hF);
        check("rst_mid seg", {25'h0, segments_no}, 32'h7F);
        check("rst_mid frame_done", {31'h0, frame_done_o}, 32'h0);
        rst_i  = 1'b0;
        load_i = 1'b0;
        @(negedge clk);
        check("rst_resume guard", {28'h0, digit_sel_no}, 32'hF);
        for (int c = 0; c < SD - GC; c++) begin
            @(negedge clk);
            check("rst_resume anode", {28'h0, digit_sel_no}, 32'hE);
            check("rst_resume seg", {25'h0, segments_no}, 32'h40);
        end
        run_frame(7'h40, 7'h40, 7'h40, 7'h40, "after_rst_load");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
